// File: rtl/prefix_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined Brent-Kung prefix adder.
package prefix_adder_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // hi covers the more significant span, lo the less significant one
  function automatic gp_t gp_merge(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic int LOG2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int NGROUPS(input int width, input int groupsize);
    return width / groupsize;
  endfunction

  function automatic bit IS_POW2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/gp_combine.sv
// Single (G,P) merge cell used by both sweeps of the group prefix tree.
module gp_combine
  import prefix_adder_pkg::*;
(
  input  gp_t hi,
  input  gp_t lo,
  output gp_t y
);
  assign y = gp_merge(hi, lo);
endmodule

// File: rtl/pipelined_prefix_adder.sv
// 3-stage Brent-Kung adder with valid/ready flow control and a passthrough tag.
// Optional N/Z/C/V flags are generated when PREFIX_ADDER_FLAGS_EN is defined.
module pipelined_prefix_adder
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int GROUPSIZE = 4,
  parameter int TAG_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
);
  localparam int NG  = NGROUPS(WIDTH, GROUPSIZE);
  localparam int LG  = LOG2(NG);
  localparam int ND  = LG - 1;
  localparam int GLW = NG * (GROUPSIZE - 1);

  if (!IS_POW2(WIDTH) || !IS_POW2(GROUPSIZE) || GROUPSIZE < 2 || WIDTH < 4 * GROUPSIZE) begin : g_param_check
    $error("pipelined_prefix_adder: WIDTH/GROUPSIZE must be powers of 2, GROUPSIZE >= 2, WIDTH >= 4*GROUPSIZE");
  end

  logic v1, v2, v3, adv1, adv2, adv3;
  assign adv3     = !v3 || out_ready;
  assign adv2     = !v2 || adv3;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;

  // Stage 1: bit and group generate/propagate
  logic [WIDTH-1:0] bit_g, bit_p;
  logic [GLW-1:0]   g_lo_d;
  gp_t              grp_d [NG];
  assign bit_g = in_a & in_b;
  assign bit_p = in_a ^ in_b;

  // Only the lower GROUPSIZE-1 bit generates of each group are needed later for the in-group ripple
  always_comb begin
    g_lo_d = '0;
    for (int j = 0; j < NG; j++) begin
      grp_d[j] = gp_t'{g: bit_g[j*GROUPSIZE], p: bit_p[j*GROUPSIZE]};
      for (int k = 1; k < GROUPSIZE; k++) begin
        grp_d[j] = gp_merge(gp_t'{g: bit_g[j*GROUPSIZE+k], p: bit_p[j*GROUPSIZE+k]}, grp_d[j]);
        g_lo_d[j*(GROUPSIZE-1)+k-1] = bit_g[j*GROUPSIZE+k-1];
      end
    end
  end

  logic [WIDTH-1:0] p1;
  logic [GLW-1:0]   g1;
  gp_t              grp1 [NG];
  logic             cin1;
  logic [TAG_W-1:0] tag1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      p1   <= '0;
      g1   <= '0;
      cin1 <= 1'b0;
      tag1 <= '0;
      for (int j = 0; j < NG; j++) grp1[j] <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        p1   <= bit_p;
        g1   <= g_lo_d;
        cin1 <= in_cin;
        tag1 <= in_tag;
        for (int j = 0; j < NG; j++) grp1[j] <= grp_d[j];
      end
    end
  end

  // Up-sweep: level l merges nodes i with (i+1) a multiple of 2^(l+1)
  for (genvar l = 0; l < LG; l++) begin : g_up
    gp_t prv [NG];
    gp_t nxt [NG];
    if (l == 0) begin : g_src
      assign prv = grp1;
    end else begin : g_src
      assign prv = g_up[l-1].nxt;
    end
    for (genvar i = 0; i < NG; i++) begin : g_cell
      if (((i + 1) % (2 << l)) == 0) begin : g_m
        gp_combine u_cell (.hi(prv[i]), .lo(prv[i - (1 << l)]), .y(nxt[i]));
      end else begin : g_p
        assign nxt[i] = prv[i];
      end
    end
  end

  gp_t up_d [NG];
  assign up_d = g_up[LG-1].nxt;

  logic [WIDTH-1:0] p2;
  logic [GLW-1:0]   g2;
  gp_t              up2 [NG];
  logic             cin2;
  logic [TAG_W-1:0] tag2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      p2   <= '0;
      g2   <= '0;
      cin2 <= 1'b0;
      tag2 <= '0;
      for (int j = 0; j < NG; j++) up2[j] <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        p2   <= p1;
        g2   <= g1;
        cin2 <= cin1;
        tag2 <= tag1;
        for (int j = 0; j < NG; j++) up2[j] <= up_d[j];
      end
    end
  end

  // Down-sweep fills the remaining prefixes, widest span first
  for (genvar d = 0; d < ND; d++) begin : g_dn
    localparam int SPAN = 1 << (ND - 1 - d);
    gp_t prv [NG];
    gp_t nxt [NG];
    if (d == 0) begin : g_src
      assign prv = up2;
    end else begin : g_src
      assign prv = g_dn[d-1].nxt;
    end
    for (genvar i = 0; i < NG; i++) begin : g_cell
      if ((i + 1 >= 3 * SPAN) && (((i + 1 - SPAN) % (2 * SPAN)) == 0)) begin : g_m
        gp_combine u_cell (.hi(prv[i]), .lo(prv[i - SPAN]), .y(nxt[i]));
      end else begin : g_p
        assign nxt[i] = prv[i];
      end
    end
  end

  gp_t pre [NG];
  assign pre = g_dn[ND-1].nxt;

  // Prefixes exclude cin, so it is applied through the prefix propagate here
  logic [NG-1:0]    c_grp;
  logic [WIDTH-1:0] c_bit, sum_d;
  logic             cout_d;
  always_comb begin
    c_grp    = '0;
    c_bit    = '0;
    c_grp[0] = cin2;
    for (int j = 1; j < NG; j++) c_grp[j] = pre[j-1].g | (pre[j-1].p & cin2);
    for (int j = 0; j < NG; j++) begin
      c_bit[j*GROUPSIZE] = c_grp[j];
      for (int k = 1; k < GROUPSIZE; k++) begin
        c_bit[j*GROUPSIZE+k] = g2[j*(GROUPSIZE-1)+k-1] |
                               (p2[j*GROUPSIZE+k-1] & c_bit[j*GROUPSIZE+k-1]);
      end
    end
  end
  assign cout_d = pre[NG-1].g | (pre[NG-1].p & cin2);
  assign sum_d  = p2 ^ c_bit;

  logic [WIDTH-1:0] sum3;
  logic             cout3;
  logic [TAG_W-1:0] tag3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3    <= 1'b0;
      sum3  <= '0;
      cout3 <= 1'b0;
      tag3  <= '0;
    end else if (adv3) begin
      v3 <= v2;
      if (v2) begin
        sum3  <= sum_d;
        cout3 <= cout_d;
        tag3  <= tag2;
      end
    end
  end

`ifdef PREFIX_ADDER_FLAGS_EN
  logic [3:0] flags3;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags3 <= '0;
    else if (adv3 && v2) flags3 <= {sum_d[WIDTH-1], sum_d == '0, cout_d, c_bit[WIDTH-1] ^ cout_d};
  end
  assign out_flags = flags3;
`else
  assign out_flags = 4'b0;
`endif

  assign out_valid = v3;
  assign out_sum   = sum3;
  assign out_cout  = cout3;
  assign out_tag   = tag3;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed and random checks for pipelined_prefix_adder at its default parameters.
module tb_pipelined_prefix_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
  logic [31:0] in_a, in_b, out_sum;
  logic [4:0]  in_tag, out_tag;
  logic [3:0]  out_flags;

  pipelined_prefix_adder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_tag(out_tag), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic [4:0]  tag;
    logic [3:0]  flags;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic acc, took, ordy;
  int   k, acc_stall, n_out, n_acc, early, bubbles;
  logic [31:0] snap_sum, ra, rb;
  logic [4:0]  snap_tag, rt;
  logic        rc;
  exp_t        idle_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] hf(input logic [3:0] f);
`ifdef PREFIX_ADDER_FLAGS_EN
    return f;
`else
    return 4'b0;
`endif
  endfunction

  function automatic exp_t mk(input logic [31:0] s, input logic c, input logic [4:0] t, input logic [3:0] f);
    exp_t e;
    e.sum = s; e.cout = c; e.tag = t; e.flags = hf(f);
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic [4:0] t);
    logic [32:0] f;
    f = {1'b0, a} + {1'b0, b} + {32'b0, ci};
    return mk(f[31:0], f[32], t,
              {f[31], f[31:0] == 32'b0, f[32], (a[31] == b[31]) && (f[31] != a[31])});
  endfunction

  // Drive at the negedge, settle, then account for both handshakes of the coming posedge
  task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b, input logic ci,
                       input logic [4:0] tg, input exp_t e, input logic ordy_i,
                       output logic acc_o, output logic took_o);
    exp_t h;
    in_valid = iv; in_a = a; in_b = b; in_cin = ci; in_tag = tg; out_ready = ordy_i;
    #1;
    acc_o  = iv && in_ready;
    took_o = out_valid && out_ready;
    if (acc_o) q.push_back(e);
    if (took_o) begin
      n_assert++;
      assert (q.size() > 0) else begin
        n_fail++;
        $error("FAIL spurious_result: observed tag=%0h expected no result", out_tag);
      end
      if (q.size() > 0) begin
        h = q.pop_front();
        check("sum", out_sum, h.sum);
        check("cout", out_cout, h.cout);
        check("tag", out_tag, h.tag);
        check("flags", out_flags, h.flags);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy_i);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 5'h0, idle_e, ordy_i, acc, took);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    idle_e = mk(32'h0, 1'b0, 5'h0, 4'h0);
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_cout, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Latency: exactly three edges from acceptance to out_valid
    cycle(1'b1, 32'h1, 32'h2, 1'b0, 5'd5, mk(32'h3, 1'b0, 5'd5, 4'b0000), 1'b1, acc, took);
    check("lat_accept", acc, 1);
    check("lat_valid_1", out_valid, 0);
    idle(1'b1);
    check("lat_valid_2", out_valid, 0);
    idle(1'b1);
    check("lat_valid_3", out_valid, 1);
    idle(1'b1);
    check("lat_drained", out_valid, 0);

    // Carry-chain corner cases back to back
    cycle(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 5'd1, mk(32'h0, 1'b1, 5'd1, 4'b0110), 1'b1, acc, took);
    cycle(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 5'd2, mk(32'h8000_0000, 1'b0, 5'd2, 4'b1001), 1'b1, acc, took);
    cycle(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 5'd3, mk(32'h0, 1'b1, 5'd3, 4'b0111), 1'b1, acc, took);
    cycle(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 5'd4, mk(32'h0, 1'b1, 5'd4, 4'b0110), 1'b1, acc, took);
    cycle(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 5'd6, mk(32'h0001_0000, 1'b0, 5'd6, 4'b0000), 1'b1, acc, took);
    repeat (5) idle(1'b1);
    check("carry_drained", q.size(), 0);

    // Backpressure: out_ready low for 5 cycles while streaming 8 ops
    k = 0; acc_stall = 0; n_out = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      ordy = (cyc >= 5);
      if (cyc == 3) begin
        snap_sum = out_sum;
        snap_tag = out_tag;
      end
      if (cyc == 4) begin
        check("bp_stall_valid", out_valid, 1);
        check("bp_stall_sum", out_sum, snap_sum);
        check("bp_stall_tag", out_tag, snap_tag);
      end
      if (k < 8) begin
        ra = 32'h0100_0000 * k + 32'h7; rb = 32'h3 * k + 32'hFFFF_FFF0;
        rc = k[0]; rt = 5'(k + 16);
        cycle(1'b1, ra, rb, rc, rt, model(ra, rb, rc, rt), ordy, acc, took);
      end else begin
        idle(ordy);
      end
      if (cyc == 3 || cyc == 4) check("bp_in_ready_low", acc, 0);
      if (acc) k++;
      if (acc && cyc < 5) acc_stall++;
      if (took) n_out++;
    end
    check("bp_accepts_in_stall", acc_stall, 3);
    check("bp_result_count", n_out, 8);
    check("bp_queue_empty", q.size(), 0);

    // Full throughput with random operands
    n_acc = 0; early = 0; bubbles = 0;
    for (int cyc = 0; cyc < 103; cyc++) begin
      if (cyc < 100) begin
        ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rt = 5'($urandom_range(0, 31));
        if (cyc % 10 == 0) rb = ~ra;
        cycle(1'b1, ra, rb, rc, rt, model(ra, rb, rc, rt), 1'b1, acc, took);
      end else begin
        idle(1'b1);
      end
      if (acc) n_acc++;
      if (cyc < 3) begin
        if (took) early++;
      end else if (!took) begin
        bubbles++;
      end
    end
    check("tp_accepts", n_acc, 100);
    check("tp_fill_results", early, 0);
    check("tp_bubbles", bubbles, 0);
    check("tp_queue_empty", q.size(), 0);

    // Asynchronous reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h5 + i, 32'h6, 1'b0, 5'(i + 1), model(32'h5 + i, 32'h6, 1'b0, 5'(i + 1)), 1'b0, acc, took);
      check("mid_accept", acc, 1);
    end
    check("mid_full_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sum", out_sum, 0);
    check("mid_rst_tag", out_tag, 0);
    check("mid_rst_cout", out_cout, 0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 6; i++) begin
      check("post_rst_no_stale", out_valid, 0);
      idle(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
